// File: rtl/bloom_filter_multi_if.sv
// SRAM read/write port and MED fifo port of bloom_filter_multi.
// master: the filter updater; slave: SRAM arbiter / MED fifo side.
interface bloom_filter_multi_if #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int DATA_WIDTH      = 64
);
    logic                       rd_req;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr;
    logic                       rd_ack;
    logic                       rd_vld;
    logic [SRAM_DATA_WIDTH-1:0] rd_data;
    logic                       wr_req;
    logic [SRAM_ADDR_WIDTH-1:0] wr_addr;
    logic [SRAM_DATA_WIDTH-1:0] wr_data;
    logic                       wr_ack;
    logic [DATA_WIDTH-1:0]      out_data;
    logic                       out_wr;
    logic                       out_full;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, out_data, out_wr,
        input  rd_ack, rd_vld, rd_data, wr_ack, out_full
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, out_data, out_wr,
        output rd_ack, rd_vld, rd_data, wr_ack, out_full
    );
endinterface

// File: rtl/bloom_filter_multi.sv
// Multi-hash counting Bloom filter updater. Each queued tuple carries
// NUM_HASHES SRAM line indices; every line gets a read-modify-write of its
// time buckets (data: increment current bucket, ack: decrement newest
// non-empty bucket). Ack records whose hashes agree emit {tuple, latency}
// as two words to the MED fifo.
// Optional macro BLOOM_FILTER_STATS_EN builds the statistics counters;
// without it the stat outputs are tied to zero.
module bloom_filter_multi #(
    parameter int NUM_HASHES      = 4,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int NUM_BITS_BUCKET = 4,
    parameter int RESERVED        = 16,
    parameter int NUM_BUCKETS     = (SRAM_DATA_WIDTH - RESERVED) / NUM_BITS_BUCKET,
    parameter int BKT_W           = $clog2(NUM_BUCKETS),
    parameter int TUPLE_WIDTH     = 96,
    parameter int DATA_WIDTH      = 64,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_wr,
    output logic                                  in_rdy,
    input  logic                                  is_ack,
    input  logic [TUPLE_WIDTH-1:0]                tuple,
    input  logic [NUM_HASHES*SRAM_ADDR_WIDTH-1:0] indices,
    input  logic [BKT_W-1:0]                      cur_bucket,
    bloom_filter_multi_if.master                  bus,
    output logic [31:0]                           stat_records,
    output logic [31:0]                           stat_drops,
    output logic [31:0]                           stat_mismatch
);
    localparam int AW    = SRAM_ADDR_WIDTH;
    localparam int NBB   = NUM_BITS_BUCKET;
    localparam int KW    = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1;
    localparam int ENT_W = 1 + TUPLE_WIDTH + NUM_HASHES * AW;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int LOW_W = TUPLE_WIDTH - DATA_WIDTH;
    localparam int PAD_W = DATA_WIDTH - LOW_W - BKT_W;
    localparam logic [NBB-1:0] BKT_ONE = 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] EMIT1   = 3'd5;
    localparam logic [2:0] EMIT2   = 3'd6;

    logic [ENT_W-1:0]           mem [DEPTH];
    logic [FIFO_DEPTH_BITS:0]   wp, rp;
    logic                       empty, full, push, pop;
    logic [ENT_W-1:0]           head;
    logic                       head_ack;
    logic [TUPLE_WIDTH-1:0]     head_tuple;
    logic [NUM_HASHES*AW-1:0]   head_indices;

    logic [2:0]                 state;
    logic [KW-1:0]              k;
    logic                       last_k;
    logic [BKT_W-1:0]           cb;
    logic                       rd_req_q, wr_req_q, out_wr_q;
    logic [AW-1:0]              rd_addr_q, wr_addr_q;
    logic [SRAM_DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0]      out_data_q;
    logic [BKT_W-1:0]           cur_lat;
    logic                       cur_valid;
    logic [BKT_W-1:0]           lat [NUM_HASHES];
    logic                       valid [NUM_HASHES];

    logic [SRAM_DATA_WIDTH-1:0] upd_line;
    logic [BKT_W-1:0]           upd_lat;
    logic                       upd_valid;
    logic                       all_match;

    assign empty        = (wp == rp);
    assign full         = (wp[FIFO_DEPTH_BITS] != rp[FIFO_DEPTH_BITS]) &&
                          (wp[FIFO_DEPTH_BITS-1:0] == rp[FIFO_DEPTH_BITS-1:0]);
    assign in_rdy       = !full;
    assign push         = in_wr && !full;
    assign head         = mem[rp[FIFO_DEPTH_BITS-1:0]];
    assign head_ack     = head[ENT_W-1];
    assign head_tuple   = head[ENT_W-2 -: TUPLE_WIDTH];
    assign head_indices = head[NUM_HASHES*AW-1:0];
    assign last_k       = (k == KW'(NUM_HASHES - 1));

    assign bus.rd_req   = rd_req_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_req   = wr_req_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.out_wr   = out_wr_q;
    assign bus.out_data = out_data_q;

    // Request fifo storage (first-word-fall-through head)
    always_ff @(posedge clk) begin
        if (push) mem[wp[FIFO_DEPTH_BITS-1:0]] <= {is_ack, tuple, indices};
    end

    // Request fifo pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    // Record ends on leaving EMIT2, on a drop, or on a final write without emission
    always_comb begin
        pop = (state == EMIT2) || (state == EMIT1 && bus.out_full) ||
              (state == WR_WAIT && last_k && !(head_ack && all_match));
    end

    // Line update computed from the returning read data
    always_comb begin
        logic [NBB-1:0] bkt;
        int unsigned    pos;
        upd_line  = bus.rd_data;
        upd_lat   = '0;
        upd_valid = 1'b0;
        bkt       = '0;
        pos       = 0;
        if (!head_ack) begin
            bkt = bus.rd_data[RESERVED + int'(cb) * NBB +: NBB];
            if (bkt != '1) upd_line[RESERVED + int'(cb) * NBB +: NBB] = bkt + BKT_ONE;
            upd_valid = 1'b1;
        end else begin
            for (int unsigned j = 0; j < NUM_BUCKETS; j++) begin
                pos = (32'(cb) + 32'(NUM_BUCKETS) - j) % 32'(NUM_BUCKETS);
                bkt = bus.rd_data[RESERVED + pos * NBB +: NBB];
                if (!upd_valid && bkt != '0) begin
                    upd_line[RESERVED + pos * NBB +: NBB] = bkt - BKT_ONE;
                    upd_lat   = BKT_W'(j);
                    upd_valid = 1'b1;
                end
            end
        end
    end

    // Agreement across hashes; the current hash's result is not yet stored in lat/valid
    always_comb begin
        logic [BKT_W-1:0] ref_lat;
        logic [BKT_W-1:0] li;
        logic             vi;
        all_match = 1'b1;
        ref_lat   = (k == '0) ? cur_lat : lat[0];
        li        = '0;
        vi        = 1'b0;
        for (int unsigned i = 0; i < NUM_HASHES; i++) begin
            if (KW'(i) == k) begin
                li = cur_lat;
                vi = cur_valid;
            end else begin
                li = lat[i];
                vi = valid[i];
            end
            if (!vi || li != ref_lat) all_match = 1'b0;
        end
    end

    // Record sequencer: per-index read-modify-write, then optional two-word emission
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            cb         <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            cur_lat    <= '0;
            cur_valid  <= 1'b0;
            for (int unsigned i = 0; i < NUM_HASHES; i++) begin
                lat[i]   <= '0;
                valid[i] <= 1'b0;
            end
        end else begin
            out_wr_q <= 1'b0;
            case (state)
                IDLE: if (!empty) begin
                    state     <= RD_REQ;
                    k         <= '0;
                    cb        <= cur_bucket;
                    rd_req_q  <= 1'b1;
                    rd_addr_q <= head_indices[0 +: AW];
                end
                RD_REQ, RD_WAIT: begin
                    if (state == RD_REQ && bus.rd_ack) begin
                        rd_req_q <= 1'b0;
                        state    <= RD_WAIT;
                    end
                    // rd_vld may coincide with rd_ack; capture straight from RD_REQ then
                    if ((state == RD_WAIT || bus.rd_ack) && bus.rd_vld) begin
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= rd_addr_q;
                        wr_data_q <= upd_line;
                        cur_lat   <= upd_lat;
                        cur_valid <= upd_valid;
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: if (bus.wr_ack) begin
                    wr_req_q <= 1'b0;
                    state    <= WR_WAIT;
                end
                WR_WAIT: begin
                    lat[k]   <= cur_lat;
                    valid[k] <= cur_valid;
                    if (!last_k) begin
                        k         <= k + 1'b1;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= head_indices[(int'(k) + 1) * AW +: AW];
                        state     <= RD_REQ;
                    end else if (head_ack && all_match) begin
                        state <= EMIT1;
                    end else begin
                        state <= IDLE;
                    end
                end
                EMIT1: if (bus.out_full) begin
                    state <= IDLE;
                end else begin
                    out_data_q <= head_tuple[TUPLE_WIDTH-1 -: DATA_WIDTH];
                    out_wr_q   <= 1'b1;
                    state      <= EMIT2;
                end
                EMIT2: begin
                    out_data_q <= {head_tuple[LOW_W-1:0], {PAD_W{1'b0}}, lat[0]};
                    out_wr_q   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLOOM_FILTER_STATS_EN
    logic [31:0] rec_q, drop_q, mis_q;

    // Statistics counters, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q  <= '0;
            drop_q <= '0;
            mis_q  <= '0;
        end else begin
            if (state == EMIT2) rec_q <= rec_q + 32'd1;
            if (state == EMIT1 && bus.out_full) drop_q <= drop_q + 32'd1;
            if (state == WR_WAIT && last_k && head_ack && !all_match) mis_q <= mis_q + 32'd1;
        end
    end

    assign stat_records  = rec_q;
    assign stat_drops    = drop_q;
    assign stat_mismatch = mis_q;
`else
    assign stat_records  = '0;
    assign stat_drops    = '0;
    assign stat_mismatch = '0;
`endif
endmodule

// File: doc/bloom_filter_multi.md
Name: bloom_filter_multi

Overview:
- Parametrised successor to the two-hash counting Bloom filter updater.
- Takes one tuple per request with NUM_HASHES SRAM line indices and updates the line for each index:
  - data packet: increment the current time bucket;
  - ack packet: decrement the newest non-empty bucket and measure latency in buckets.
- Emits {tuple, latency} records to the MED fifo when every hash agrees.
- Sits between the hash units and the SRAM arbiter. Bucket rotation (cur_bucket) comes from the external shifter/watchdog.

Parameters:
- NUM_HASHES, 4, number of SRAM lines touched per tuple (>=1).
- SRAM_ADDR_WIDTH, 19, SRAM address width.
- SRAM_DATA_WIDTH, 72, SRAM line width.
- NUM_BITS_BUCKET, 4, bits per counter bucket.
- RESERVED, 16, low line bits preserved untouched.
- NUM_BUCKETS, (SRAM_DATA_WIDTH-RESERVED)/NUM_BITS_BUCKET, buckets per line (14).
- BKT_W, log2ceil(NUM_BUCKETS), bucket index/latency width (4).
- TUPLE_WIDTH, 96, {ip_src, ip_dst, ports}.
- DATA_WIDTH, 64, MED fifo word width.
- FIFO_DEPTH_BITS, 3, input request fifo depth = 2^FIFO_DEPTH_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_wr  in  1  request write strobe
- in_rdy  out  1  !request_fifo_full
- is_ack  in  1  1 = ack packet, 0 = data packet
- tuple  in  TUPLE_WIDTH  flow tuple
- indices  in  NUM_HASHES*SRAM_ADDR_WIDTH  index k at [(k+1)*SRAM_ADDR_WIDTH-1 : k*SRAM_ADDR_WIDTH]
- cur_bucket  in  BKT_W  current time bucket (0..NUM_BUCKETS-1)
- rd_req  out  1, rd_addr  out  SRAM_ADDR_WIDTH, rd_ack  in  1, rd_vld  in  1, rd_data  in  SRAM_DATA_WIDTH  SRAM read port
- wr_req  out  1, wr_addr  out  SRAM_ADDR_WIDTH, wr_data  out  SRAM_DATA_WIDTH, wr_ack  in  1  SRAM write port
- out_data  out  DATA_WIDTH, out_wr  out  1, out_full  in  1  MED fifo interface
- stat_records, stat_drops, stat_mismatch  out  32 each  statistics counters (see Optional Feature)

Behaviour:
- Reset values:
  - State IDLE.
  - rd_req, wr_req, out_wr = 0.
  - rd_addr, wr_addr, wr_data, out_data = 0.
  - Request fifo empty.
  - Hash counter k = 0; latency registers 0; stats 0.
- Reset mid-operation abandons the record. Any SRAM access in flight is dropped, and a late rd_vld/wr_ack is ignored while in IDLE.
- Request fifo: first-word-fall-through. Entry is popped at record end, i.e. on leaving EMIT2, or on the final WR_WAIT exit when no emission occurs.
- Writing while full is a protocol error: data is discarded and in_rdy is already low.
- Per record, cur_bucket is latched to cb on IDLE->RD_REQ; later changes do not affect that record.
- Indices are processed strictly in order k = 0..NUM_HASHES-1 as read-modify-write. Duplicate indices therefore accumulate correctly (two increments on the same line give +2).
- FSM states:
  - IDLE: fifo non-empty -> RD_REQ, k = 0.
  - RD_REQ: rd_req = 1, rd_addr = index k; hold until rd_ack -> RD_WAIT.
  - RD_WAIT: capture rd_data on rd_vld. rd_vld may coincide with rd_ack; then capture in that cycle and go directly to WR_REQ.
  - WR_REQ: wr_addr = index k, wr_data = updated line; hold wr_req until wr_ack -> WR_WAIT.
  - WR_WAIT (one cycle): store lat[k] and valid[k]. If k < NUM_HASHES-1: k++, -> RD_REQ. Otherwise -> EMIT1 when is_ack && all valid && all lat equal; else pop, -> IDLE.
  - EMIT1: if out_full, drop the record (pop, stat_drops++, -> IDLE). Otherwise out_data = tuple[95:32], out_wr = 1, -> EMIT2.
  - EMIT2: out_data = {tuple[31:0], zero-extended lat}, out_wr = 1 unconditionally. Records are never split. Pop, stat_records++, -> IDLE.
- Bucket i occupies bits [RESERVED+(i+1)*NUM_BITS_BUCKET-1 : RESERVED+i*NUM_BITS_BUCKET]. Bits [RESERVED-1:0] are written back unchanged.
- Data update: bucket cb += 1, saturating at 2^NUM_BITS_BUCKET-1. lat = 0, valid = 1.
- Ack update: search j = 0..NUM_BUCKETS-1 for the first non-zero bucket at (cb - j) mod NUM_BUCKETS, with wrap below 0 to NUM_BUCKETS-1.
  - Found: decrement that bucket; lat = j; valid = 1.
  - None found: line unchanged; valid = 0.
- Mismatch between hashes (unequal lat or any invalid) on an ack record: stat_mismatch++.
- Throughput: at most one SRAM request outstanding.

Optional Feature:
- BLOOM_FILTER_STATS_EN defined:
  - stat_records, stat_drops and stat_mismatch are 32-bit counters, wrapping at 2^32-1 -> 0, cleared by reset.
- Undefined:
  - The three outputs are tied to 0 and no counter flops are built. Datapath behaviour is identical.

Test Plan:
- Data record, indices {5,9,5,12}, cb = 3, SRAM all zero, zero-latency SRAM model -> line 9 bucket3 = 1; line 5 bucket3 = 2; reserved bits unchanged; no out_wr; four reads and four writes in index order.
- Ack record, all lines with only bucket1 = 1, cb = 4 -> each bucket1 becomes 0; out words 0x{tuple[95:32]} then {tuple[31:0], 32'd3}; stat_records = 1.
- Wrap: ack with bucket13 = 2 only, cb = 1 -> lat = 2, bucket13 = 1.
- Ack where line 2 has no set bucket -> no output, stat_mismatch = 1, remaining lines still decremented.
- out_full = 1 in EMIT1 -> no out_wr, stat_drops = 1, next request is processed.
- Push 8 requests, then in_rdy = 0; assert reset mid-RD_WAIT -> all outputs 0, in_rdy = 1, late rd_vld ignored.
